// File: rtl/sr_counter_ctrl.sv
// Run controller and count state for a WIDTH-bit counter built from clocked SR cells.
// Produces set/reset excitation vectors that move each cell from its present to its next value.
module sr_counter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             up_dn,
  input  logic             one_shot,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] s_vec,
  output logic [WIDTH-1:0] r_vec,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             at_term;
  logic [WIDTH-1:0] wrap_val;
  logic [WIDTH-1:0] step_val;

  always_comb begin
    at_term  = up_dn ? (count_q >= limit) : (count_q == '0);
    wrap_val = up_dn ? '0 : limit;
    step_val = up_dn ? (count_q + 1'b1) : (count_q - 1'b1);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (rst) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!stop) begin
            if (load)       count_d = load_val;
            else if (start) state_d = RUN;
          end
        end
        RUN: begin
          // Load is deliberately ignored while running.
          if (stop)          state_d = PAUSE;
          else if (!at_term) count_d = step_val;
          else if (!one_shot) count_d = wrap_val;
          else               state_d = DONE;
        end
        PAUSE: begin
          if (!stop) begin
            if (load)       count_d = load_val;
            else if (start) state_d = RUN;
          end
        end
        DONE: begin
          if (!stop) begin
            if (load) begin
              count_d = load_val;
              state_d = IDLE;
            end else if (start) begin
              count_d = wrap_val;
              state_d = RUN;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Set only bits rising 0->1, reset only bits falling 1->0, so S and R are never both high.
  assign s_vec = count_d & ~count_q;
  assign r_vec = ~count_d & count_q;

  assign tc    = (state_q == RUN) && at_term && !stop && !rst;
  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_sr_counter_ctrl.sv
// Self-checking bench for sr_counter_ctrl: directed vector table, then randomized
// stimulus checked against a behavioural model of the run controller.
module tb_sr_counter_ctrl;
  localparam int W   = 4;
  localparam int MOD = 1 << W;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic         clk = 1'b0;
  logic         rst, start, stop, load, up_dn, one_shot;
  logic [W-1:0] load_val, limit;
  logic [W-1:0] count, s_vec, r_vec;
  logic         busy, tc, done;

  int n_pass  = 0;
  int n_total = 0;
  int m_count = 0;
  int m_state = M_IDLE;

  always #5 clk = ~clk;

  sr_counter_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .limit(limit), .up_dn(up_dn), .one_shot(one_shot),
    .count(count), .s_vec(s_vec), .r_vec(r_vec), .busy(busy), .tc(tc), .done(done)
  );

  typedef struct {
    bit         rst, start, stop, load;
    logic [3:0] lv, lim;
    bit         ud, os;
    bit         e_tc;
    logic [3:0] e_cnt;
    bit         e_busy, e_done;
    bit         sr;
    logic [3:0] e_s, e_r;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit r, bit st, bit sp, bit ld, int lv, int lim, bit ud, bit os,
                              bit e_tc, int e_cnt, bit e_busy, bit e_done);
    vec_t v;
    v.rst = r; v.start = st; v.stop = sp; v.load = ld;
    v.lv = 4'(lv); v.lim = 4'(lim); v.ud = ud; v.os = os;
    v.e_tc = e_tc; v.e_cnt = 4'(e_cnt); v.e_busy = e_busy; v.e_done = e_done;
    v.sr = 1'b0; v.e_s = '0; v.e_r = '0;
    return v;
  endfunction

  task automatic add_sr(int s, int r);
    vq[vq.size()-1].sr  = 1'b1;
    vq[vq.size()-1].e_s = 4'(s);
    vq[vq.size()-1].e_r = 4'(r);
  endtask

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: pick the winning request by priority, then apply it to the run state.
  function automatic void model_eval(output int nc, output int ns, output bit mt);
    string req;
    bit    term;
    int    wrapv;
    nc = m_count; ns = m_state; mt = 1'b0;
    if (rst)        req = "reset";
    else if (stop)  req = "stop";
    else if (load)  req = "load";
    else if (start) req = "start";
    else            req = "none";
    term  = up_dn ? (m_count >= int'(limit)) : (m_count == 0);
    wrapv = up_dn ? 0 : int'(limit);
    if (req == "reset") begin
      nc = 0; ns = M_IDLE;
    end else if (m_state == M_RUN) begin
      if (req == "stop") ns = M_PAUSE;
      else begin
        mt = term;
        if (!term)          nc = up_dn ? (m_count + 1) % MOD : (m_count + MOD - 1) % MOD;
        else if (!one_shot) nc = wrapv;
        else                ns = M_DONE;
      end
    end else if (req == "load") begin
      nc = load_val;
      if (m_state == M_DONE) ns = M_IDLE;
    end else if (req == "start") begin
      if (m_state == M_DONE) nc = wrapv;
      ns = M_RUN;
    end
  endfunction

  // Called with inputs settled, before the edge; returns on the following negedge.
  task automatic tick();
    int         nc, ns;
    bit         mt;
    logic [3:0] pc, ps, pr;
    model_eval(nc, ns, mt);
    chk("tc_model", int'(tc), int'(mt));
    chk("s_vec_model", int'(s_vec), nc & ~m_count & (MOD - 1));
    chk("r_vec_model", int'(r_vec), ~nc & m_count & (MOD - 1));
    chk("sr_exclusive", int'(s_vec & r_vec), 0);
    pc = count; ps = s_vec; pr = r_vec;
    @(posedge clk); #1;
    m_count = nc; m_state = ns;
    chk("count_model", int'(count), m_count);
    chk("busy_model", int'(busy), int'(m_state == M_RUN));
    chk("done_model", int'(done), int'(m_state == M_DONE));
    chk("count_from_excite", int'(count), int'((pc | ps) & ~pr));
    @(negedge clk);
  endtask

  initial begin
    // Scenario A: wrap-up count to limit 9, load ignored in RUN, then reset at count 7.
    vq.push_back(mk(0,1,0,0,0,9,1,0, 0,0,1,0));
    for (int k = 0; k < 9; k++) vq.push_back(mk(0,0,0,0,0,9,1,0, 0,k+1,1,0));
    vq.push_back(mk(0,0,0,0,0,9,1,0, 1,0,1,0)); add_sr(0, 9);
    for (int k = 1; k <= 7; k++) vq.push_back(mk(0,0,0,(k==3),12,9,1,0, 0,k,1,0));
    vq.push_back(mk(1,1,0,1,5,9,1,0, 0,0,0,0)); add_sr(0, 7);
    vq.push_back(mk(0,0,0,0,0,9,1,0, 0,0,0,0)); add_sr(0, 0);
    // Scenario B: one-shot down from 3.
    vq.push_back(mk(0,0,0,1,3,9,0,1, 0,3,0,0));
    vq.push_back(mk(0,1,0,0,3,9,0,1, 0,3,1,0));
    vq.push_back(mk(0,0,0,0,3,9,0,1, 0,2,1,0));
    vq.push_back(mk(0,0,0,0,3,9,0,1, 0,1,1,0));
    vq.push_back(mk(0,0,0,0,3,9,0,1, 0,0,1,0));
    vq.push_back(mk(0,0,0,0,3,9,0,1, 1,0,0,1));
    vq.push_back(mk(0,0,0,0,3,9,0,1, 0,0,0,1));
    // Scenario C: pause with stop+load, load in PAUSE, resume.
    vq.push_back(mk(0,0,0,1,4,15,1,0, 0,4,0,0));
    vq.push_back(mk(0,1,0,0,4,15,1,0, 0,4,1,0));
    vq.push_back(mk(0,0,0,0,4,15,1,0, 0,5,1,0));
    vq.push_back(mk(0,0,1,1,12,15,1,0, 0,5,0,0));
    vq.push_back(mk(0,0,0,1,12,15,1,0, 0,12,0,0));
    vq.push_back(mk(0,1,0,0,12,15,1,0, 0,12,1,0));
    vq.push_back(mk(0,0,0,0,12,15,1,0, 0,13,1,0));
    // Scenario D: limit lowered below count, then limit 0 in both directions.
    vq.push_back(mk(0,0,1,0,0,15,1,0, 0,13,0,0));
    vq.push_back(mk(0,0,0,1,5,15,1,0, 0,5,0,0));
    vq.push_back(mk(0,1,0,0,5,15,1,0, 0,5,1,0));
    vq.push_back(mk(0,0,0,0,5,15,1,0, 0,6,1,0));
    vq.push_back(mk(0,0,0,0,0,4,1,0, 1,0,1,0)); add_sr(0, 6);
    for (int k = 0; k < 3; k++) vq.push_back(mk(0,0,0,0,0,0,1,0, 1,0,1,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 1,0,1,0));
    vq.push_back(mk(0,0,1,0,0,0,1,0, 0,0,0,0));
    // Scenario E: one-shot up to DONE, restart from DONE wraps to 0.
    vq.push_back(mk(0,0,0,1,2,3,1,1, 0,2,0,0));
    vq.push_back(mk(0,1,0,0,2,3,1,1, 0,2,1,0));
    vq.push_back(mk(0,0,0,0,2,3,1,1, 0,3,1,0));
    vq.push_back(mk(0,0,0,0,2,3,1,1, 1,3,0,1));
    vq.push_back(mk(0,1,0,0,2,3,1,1, 0,0,1,0)); add_sr(0, 3);
    vq.push_back(mk(0,0,1,0,2,3,1,1, 0,0,0,0));

    rst = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0;
    load_val = '0; limit = '0; up_dn = 1'b1; one_shot = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("reset_count", int'(count), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_tc", int'(tc), 0);
    chk("reset_s_vec", int'(s_vec), 0);
    chk("reset_r_vec", int'(r_vec), 0);
    rst = 1'b0;

    foreach (vq[i]) begin
      rst = vq[i].rst; start = vq[i].start; stop = vq[i].stop; load = vq[i].load;
      load_val = vq[i].lv; limit = vq[i].lim; up_dn = vq[i].ud; one_shot = vq[i].os;
      #1;
      chk($sformatf("vec%0d_tc", i), int'(tc), int'(vq[i].e_tc));
      if (vq[i].sr) begin
        chk($sformatf("vec%0d_s_vec", i), int'(s_vec), int'(vq[i].e_s));
        chk($sformatf("vec%0d_r_vec", i), int'(r_vec), int'(vq[i].e_r));
      end
      tick();
      chk($sformatf("vec%0d_count", i), int'(count), int'(vq[i].e_cnt));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vq[i].e_busy));
      chk($sformatf("vec%0d_done", i), int'(done), int'(vq[i].e_done));
    end

    for (int c = 0; c < 12000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 2) == 0);
      stop  = ($urandom_range(0, 5) == 0);
      load  = ($urandom_range(0, 7) == 0);
      load_val = 4'($urandom_range(0, MOD - 1));
      if ($urandom_range(0, 19) == 0) limit = 4'($urandom_range(0, MOD - 1));
      if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
      if ($urandom_range(0, 15) == 0) one_shot = ~one_shot;
      #1;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
